// File: rtl/servo_array_ctrl.sv
// Multi-channel hobby-servo pulse generator: one shared frame counter drives N_CH
// channels, and each channel's applied width is slew-limited toward its target once per frame.
module servo_array_ctrl #(
    parameter int N_CH       = 2,
    parameter int W          = 24,
    parameter int PERIOD_CYC = 2_000_000,
    parameter int MIN_CYC    = 100_000,
    parameter int MAX_CYC    = 200_000,
    parameter int SLEW_STEP  = 1_000,
    localparam int CHW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            tgt_valid,
    output logic            tgt_ready,
    input  logic [CHW-1:0]  tgt_ch,
    input  logic [W-1:0]    tgt_width,
    output logic [N_CH-1:0] servo_out,
    output logic            frame_start,
    output logic [N_CH-1:0] at_target,
    output logic            err_oor
);

    localparam logic [W-1:0] LAST_CNT = W'(PERIOD_CYC - 1);
    localparam logic [W-1:0] MIN_W    = W'(MIN_CYC);
    localparam logic [W-1:0] MAX_W    = W'(MAX_CYC);
    localparam logic [W-1:0] CENTER_W = W'((MIN_CYC + MAX_CYC) / 2);
    localparam logic [W-1:0] STEP_W   = W'(SLEW_STEP);

    logic [W-1:0]    frameCnt_q, frameCnt_d;
    logic [W-1:0]    tgtWidth_q [N_CH];
    logic [W-1:0]    tgtWidth_d [N_CH];
    logic [W-1:0]    curWidth_q [N_CH];
    logic [W-1:0]    curWidth_d [N_CH];
    logic [N_CH-1:0] servo_q, servo_d;
    logic [N_CH-1:0] atTarget_q, atTarget_d;
    logic            frameStart_q, frameStart_d;
    logic            errOor_q, errOor_d;
    logic            wrEn, inRange, frameEnd;

    function automatic logic [W-1:0] clampWidth(input logic [W-1:0] v);
        if (v < MIN_W) return MIN_W;
        if (v > MAX_W) return MAX_W;
        return v;
    endfunction

    // Magnitude is taken in the right direction so the unsigned subtraction never wraps.
    function automatic logic [W-1:0] slewToward(input logic [W-1:0] cur, input logic [W-1:0] tgt);
        logic [W-1:0] diff;
        diff = (tgt > cur) ? (tgt - cur) : (cur - tgt);
        if (SLEW_STEP == 0 || diff <= STEP_W) return tgt;
        return (tgt > cur) ? (cur + STEP_W) : (cur - STEP_W);
    endfunction

    assign tgt_ready = ~reset;

    always_comb begin
        wrEn     = tgt_valid & ~reset;
        inRange  = int'(tgt_ch) < N_CH;
        frameEnd = en && (frameCnt_q == LAST_CNT);

        frameCnt_d   = (!en || frameEnd) ? '0 : frameCnt_q + W'(1);
        frameStart_d = en && (frameCnt_q == '0);
        errOor_d     = errOor_q | (wrEn & ~inRange);

        // Slew reads the old target; a write landing on the frame-end cycle waits a frame.
        for (int i = 0; i < N_CH; i++) begin
            curWidth_d[i] = frameEnd ? slewToward(curWidth_q[i], tgtWidth_q[i]) : curWidth_q[i];
            tgtWidth_d[i] = (wrEn && inRange && int'(tgt_ch) == i) ? clampWidth(tgt_width)
                                                                    : tgtWidth_q[i];
            servo_d[i]    = en && (frameCnt_q < curWidth_q[i]);
            atTarget_d[i] = (curWidth_q[i] == tgtWidth_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frameCnt_q   <= '0;
            servo_q      <= '0;
            atTarget_q   <= '1;
            frameStart_q <= 1'b0;
            errOor_q     <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                tgtWidth_q[i] <= CENTER_W;
                curWidth_q[i] <= CENTER_W;
            end
        end else begin
            frameCnt_q   <= frameCnt_d;
            servo_q      <= servo_d;
            atTarget_q   <= atTarget_d;
            frameStart_q <= frameStart_d;
            errOor_q     <= errOor_d;
            for (int i = 0; i < N_CH; i++) begin
                tgtWidth_q[i] <= tgtWidth_d[i];
                curWidth_q[i] <= curWidth_d[i];
            end
        end
    end

    assign servo_out   = servo_q;
    assign frame_start = frameStart_q;
    assign at_target   = atTarget_q;
    assign err_oor     = errOor_q;

endmodule

// File: tb/tb_servo_array_ctrl.sv
// Self-checking bench for servo_array_ctrl: table of ramp vectors, hand-written corner
// sequences, then randomized traffic against a frame-level behavioural model.
module tb_servo_array_ctrl;

    localparam int PERIOD = 100;
    localparam int MINC   = 10;
    localparam int MAXC   = 30;
    localparam int STEP   = 4;
    localparam int CENTER = 20;

    logic       clk = 1'b0;
    logic       reset, en, tgt_valid, tgt_ready;
    logic [0:0] tgt_ch;
    logic [7:0] tgt_width;
    logic [1:0] servo_out, at_target;
    logic       frame_start, err_oor;

    logic       valid3, ready3, frame3, err3;
    logic [1:0] ch3;
    logic [7:0] width3;
    logic [2:0] servo3, at3;

    int compared = 0;
    int mismatched = 0;

    // Behavioural model state for the two-channel instance
    int         mCnt;
    int         mTgt [2];
    int         mCur [2];
    logic [1:0] eServo, eAt;
    logic       eFrame, eErr;

    typedef struct {
        int ch;
        int width;
        int expW [4];
    } vecT;
    vecT vecs [5];

    always #5 clk = ~clk;

    servo_array_ctrl #(.N_CH(2), .W(8), .PERIOD_CYC(PERIOD), .MIN_CYC(MINC),
                       .MAX_CYC(MAXC), .SLEW_STEP(STEP)) dut (
        .clk(clk), .reset(reset), .en(en), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .tgt_ch(tgt_ch), .tgt_width(tgt_width), .servo_out(servo_out),
        .frame_start(frame_start), .at_target(at_target), .err_oor(err_oor)
    );

    servo_array_ctrl #(.N_CH(3), .W(8), .PERIOD_CYC(PERIOD), .MIN_CYC(MINC),
                       .MAX_CYC(MAXC), .SLEW_STEP(STEP)) dut3 (
        .clk(clk), .reset(reset), .en(en), .tgt_valid(valid3), .tgt_ready(ready3),
        .tgt_ch(ch3), .tgt_width(width3), .servo_out(servo3),
        .frame_start(frame3), .at_target(at3), .err_oor(err3)
    );

    function automatic int clampModel(input int v);
        return (v < MINC) ? MINC : ((v > MAXC) ? MAXC : v);
    endfunction

    task automatic modelStep();
        int d;
        if (reset) begin
            mCnt = 0;
            mTgt[0] = CENTER; mTgt[1] = CENTER;
            mCur[0] = CENTER; mCur[1] = CENTER;
            eServo = 2'b00; eFrame = 1'b0; eAt = 2'b11; eErr = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                eServo[i] = en && (mCnt < mCur[i]);
                eAt[i]    = (mCur[i] == mTgt[i]);
            end
            eFrame = en && (mCnt == 0);
            if (en && mCnt == PERIOD - 1) begin
                for (int i = 0; i < 2; i++) begin
                    d = mTgt[i] - mCur[i];
                    if (d <= STEP && d >= -STEP) mCur[i] = mTgt[i];
                    else mCur[i] = mCur[i] + ((d > 0) ? STEP : -STEP);
                end
            end
            if (tgt_valid) begin
                if (int'(tgt_ch) < 2) mTgt[int'(tgt_ch)] = clampModel(int'(tgt_width));
                else eErr = 1'b1;
            end
            mCnt = en ? (mCnt + 1) % PERIOD : 0;
        end
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input int ch, input int w);
        tgt_valid = v;
        tgt_ch    = ch[0:0];
        tgt_width = w[7:0];
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic waitFrameStart();
        int guard = 0;
        while (frame_start !== 1'b1 && guard < 250) begin
            tick();
            guard++;
        end
        if (guard >= 250) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL frame_start timeout: got no pulse in 250 cycles, expected one");
        end
    endtask

    // Counts high cycles per channel over one frame starting at its frame_start sample
    task automatic measureFrame(output int w0, output int w1, output int fs);
        waitFrameStart();
        w0 = 0; w1 = 0; fs = 0;
        for (int j = 0; j < PERIOD; j++) begin
            if (servo_out[0] === 1'b1) w0++;
            if (servo_out[1] === 1'b1) w1++;
            if (frame_start === 1'b1) fs++;
            tick();
        end
    endtask

    initial begin
        int w0, w1, fs, cnt, clampW;
        logic [1:0] expAt;

        vecs[0] = '{ch: 1, width: 30,  expW: '{24, 28, 30, 30}};
        vecs[1] = '{ch: 0, width: 50,  expW: '{24, 28, 30, 30}};
        vecs[2] = '{ch: 0, width: 3,   expW: '{16, 12, 10, 10}};
        vecs[3] = '{ch: 1, width: 13,  expW: '{16, 13, 13, 13}};
        vecs[4] = '{ch: 0, width: 22,  expW: '{22, 22, 22, 22}};

        reset = 1'b1; en = 1'b0;
        applyStimulus(1'b0, 0, 0);
        valid3 = 1'b0; ch3 = 2'd0; width3 = 8'd0;
        tick();
        tick();
        checkOutput("reset servo_out", servo_out, 2'b00);
        checkOutput("reset frame_start", frame_start, 1'b0);
        checkOutput("reset at_target", at_target, 2'b11);
        checkOutput("reset err_oor", err_oor, 1'b0);
        checkOutput("reset tgt_ready", tgt_ready, 1'b0);

        // Idle enabled run: both channels at centre width, 100-cycle frame
        en = 1'b1;
        reset = 1'b0;
        tick();
        checkOutput("tgt_ready after reset", tgt_ready, 1'b1);
        for (int f = 0; f < 2; f++) begin
            measureFrame(w0, w1, fs);
            checkOutput($sformatf("idle frame%0d ch0 width", f), w0, CENTER);
            checkOutput($sformatf("idle frame%0d ch1 width", f), w1, CENTER);
            checkOutput($sformatf("idle frame%0d frame_start count", f), fs, 1);
            checkOutput($sformatf("idle frame%0d period", f), frame_start, 1'b1);
        end
        checkOutput("idle at_target", at_target, 2'b11);

        for (int k = 0; k < 5; k++) begin
            doReset();
            waitFrameStart();
            repeat (40) tick();
            applyStimulus(1'b1, vecs[k].ch, vecs[k].width);
            tick();
            applyStimulus(1'b0, 0, 0);
            tick();
            clampW = clampModel(vecs[k].width);
            expAt = 2'b11;
            expAt[vecs[k].ch] = (clampW == CENTER);
            checkOutput($sformatf("vec%0d at_target after write", k), at_target, expAt);
            for (int f = 0; f < 4; f++) begin
                measureFrame(w0, w1, fs);
                checkOutput($sformatf("vec%0d frame%0d ch0 width", k, f), w0,
                            (vecs[k].ch == 0) ? vecs[k].expW[f] : CENTER);
                checkOutput($sformatf("vec%0d frame%0d ch1 width", k, f), w1,
                            (vecs[k].ch == 1) ? vecs[k].expW[f] : CENTER);
            end
        end

        // Write landing on the last cycle of a frame is not used by that frame's update
        doReset();
        waitFrameStart();
        repeat (PERIOD - 2) tick();
        applyStimulus(1'b1, 0, 28);
        tick();
        applyStimulus(1'b0, 0, 0);
        measureFrame(w0, w1, fs);
        checkOutput("edge write frame0 ch0", w0, 20);
        measureFrame(w0, w1, fs);
        checkOutput("edge write frame1 ch0", w0, 24);
        measureFrame(w0, w1, fs);
        checkOutput("edge write frame2 ch0", w0, 28);

        // Enable dropped mid-frame, then raised again: widths and targets retained
        doReset();
        waitFrameStart();
        repeat (10) tick();
        applyStimulus(1'b1, 1, 30);
        tick();
        applyStimulus(1'b0, 0, 0);
        measureFrame(w0, w1, fs);
        checkOutput("pre-disable ch1 width", w1, 24);
        repeat (4) tick();
        en = 1'b0;
        tick();
        tick();
        checkOutput("disable servo_out low", servo_out, 2'b00);
        cnt = 0;
        for (int j = 0; j < 150; j++) begin
            if (servo_out !== 2'b00 || frame_start !== 1'b0) cnt++;
            tick();
        end
        checkOutput("disabled activity cycles", cnt, 0);
        checkOutput("disabled at_target", at_target, 2'b01);
        en = 1'b1;
        tick();
        checkOutput("re-enable frame_start", frame_start, 1'b1);
        checkOutput("re-enable servo_out", servo_out, 2'b11);
        measureFrame(w0, w1, fs);
        checkOutput("re-enable frame0 ch0", w0, 20);
        checkOutput("re-enable frame0 ch1", w1, 28);
        measureFrame(w0, w1, fs);
        checkOutput("re-enable frame1 ch1", w1, 30);

        // Reset during a pulse, with a write presented while reset is high
        repeat (5) tick();
        checkOutput("mid-pulse servo_out", servo_out, 2'b11);
        reset = 1'b1;
        applyStimulus(1'b1, 0, 30);
        tick();
        checkOutput("mid-pulse reset servo_out", servo_out, 2'b00);
        checkOutput("mid-pulse reset at_target", at_target, 2'b11);
        checkOutput("mid-pulse reset tgt_ready", tgt_ready, 1'b0);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 0, 0);
        tick();
        for (int f = 0; f < 2; f++) begin
            measureFrame(w0, w1, fs);
            checkOutput($sformatf("post-reset frame%0d ch0", f), w0, CENTER);
            checkOutput($sformatf("post-reset frame%0d ch1", f), w1, CENTER);
        end

        // Out-of-range index on the three-channel build, with frames stopped
        en = 1'b0;
        doReset();
        valid3 = 1'b1; ch3 = 2'd1; width3 = 8'd25;
        tick();
        valid3 = 1'b0;
        tick();
        checkOutput("oor in-range err", err3, 1'b0);
        checkOutput("oor in-range at_target", at3, 3'b101);
        valid3 = 1'b1; ch3 = 2'd3; width3 = 8'd12;
        tick();
        valid3 = 1'b0;
        tick();
        checkOutput("oor err set", err3, 1'b1);
        checkOutput("oor registers unchanged", at3, 3'b101);
        repeat (20) tick();
        checkOutput("oor err sticky", err3, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checkOutput("oor err cleared by reset", err3, 1'b0);
        checkOutput("oor at_target after reset", at3, 3'b111);

        // Randomized traffic compared cycle by cycle with the model
        en = 1'b1;
        doReset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    applyStimulus(1'b1, int'($urandom_range(0, 1)), int'($urandom_range(5, 35)));
                else
                    applyStimulus(1'b1, int'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
            end else begin
                applyStimulus(1'b0, 0, 0);
            end
            if ($urandom_range(0, 399) == 0) en = ~en;
            reset = ($urandom_range(0, 999) == 0);
            tick();
            checkOutput($sformatf("random cycle %0d {servo,frame,at,err}", c),
                        {servo_out, frame_start, at_target, err_oor},
                        {eServo, eFrame, eAt, eErr});
        end
        reset = 1'b0;
        applyStimulus(1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
